// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: sequences one attention pass over Q/K memories, MAC load/execute,
// OFIFO drain into psum memory, optional SFP normalisation and output generation.
// Ports: clk, reset (async, active-high), start, abort (sync cancel), ld_done,
//   exec_done, out_wr -> inst (packed instruction word), done, op_valid, busy, state.
// Build option: define ATTN_SEQ_SFP_EN to include the SFP normalisation state.
module attn_seq_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int Q_ROWS  = 16,
    parameter int K_ROWS  = 8,
    parameter int P_ROWS  = 8,
    parameter int LD_GAP  = 4,
    parameter int SFP_GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                ld_done,
    input  logic                exec_done,
    input  logic                out_wr,
    output logic [2*ADDR_W+11:0] inst,
    output logic                done,
    output logic                op_valid,
    output logic                busy,
    output logic [3:0]          state
);

    localparam int IW = 2*ADDR_W+12;
    localparam int CW = ADDR_W+1;

    // Row counts beyond the address space cannot be addressed.
    if (ADDR_W < 1 || Q_ROWS < 1 || K_ROWS < 1 || P_ROWS < 1 ||
        Q_ROWS > (1 << ADDR_W) || K_ROWS > (1 << ADDR_W) ||
        P_ROWS > (1 << ADDR_W) || LD_GAP < 1 || LD_GAP > (1 << CW) ||
        SFP_GAP < 0) begin : g_param_check
        $error("attn_seq_ctrl: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_Q_WR    = 4'd1,
        S_K_WR    = 4'd2,
        S_K_LD    = 4'd3,
        S_LD_HOLD = 4'd4,
        S_EXEC    = 4'd5,
        S_OF_HOLD = 4'd6,
        S_P_WR    = 4'd7,
        S_SFP     = 4'd8,
        S_GEN_OUT = 4'd9
    } state_t;

    localparam logic [CW-1:0] Q_LAST = CW'(Q_ROWS-1);
    localparam logic [CW-1:0] K_LAST = CW'(K_ROWS-1);
    localparam logic [CW-1:0] K_END  = CW'(K_ROWS);
    localparam logic [CW-1:0] P_LAST = CW'(P_ROWS-1);
    localparam logic [CW-1:0] G_LAST = CW'(LD_GAP-1);

    state_t          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   inst_d;
    logic            opv_d;

`ifdef ATTN_SEQ_SFP_EN
    localparam int BW = $clog2(SFP_GAP+5);
    localparam logic [BW-1:0] B_ACC  = BW'(1);
    localparam logic [BW-1:0] B_DIV  = BW'(2+SFP_GAP);
    localparam logic [BW-1:0] B_WB   = BW'(3+SFP_GAP);
    localparam logic [BW-1:0] B_LAST = BW'(4+SFP_GAP);

    // Beat position within one SFP row; cnt holds the row.
    logic [BW-1:0]   beat_q, beat_d;
`endif

    // Next state and counters
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
`ifdef ATTN_SEQ_SFP_EN
        beat_d = beat_q;
`endif
        if (abort) begin
            st_d  = S_IDLE;
            cnt_d = '0;
`ifdef ATTN_SEQ_SFP_EN
            beat_d = '0;
`endif
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_d  = S_Q_WR;
                        cnt_d = '0;
                    end
                end
                S_Q_WR: begin
                    if (cnt_q == Q_LAST) begin
                        st_d  = S_K_WR;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_K_WR: begin
                    if (cnt_q == K_LAST) begin
                        st_d  = S_K_LD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_K_LD: begin
                    // Counter parks at K_ROWS so kmem_rd stays low while load waits.
                    if (ld_done) begin
                        st_d  = S_LD_HOLD;
                        cnt_d = '0;
                    end else if (cnt_q != K_END) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LD_HOLD: begin
                    if (cnt_q == G_LAST) begin
                        st_d  = S_EXEC;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        st_d  = S_OF_HOLD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = {1'b0, ADDR_W'(cnt_q[ADDR_W-1:0] + 1'b1)};
                    end
                end
                S_OF_HOLD: begin
                    if (out_wr) begin
                        st_d  = S_P_WR;
                        cnt_d = '0;
                    end
                end
                S_P_WR: begin
                    if (cnt_q == P_LAST) begin
`ifdef ATTN_SEQ_SFP_EN
                        st_d   = S_SFP;
                        beat_d = '0;
`else
                        st_d  = S_GEN_OUT;
`endif
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef ATTN_SEQ_SFP_EN
                S_SFP: begin
                    if (beat_q == B_LAST) begin
                        beat_d = '0;
                        if (cnt_q == P_LAST) begin
                            st_d  = S_GEN_OUT;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
`endif
                S_GEN_OUT: begin
                    if (cnt_q == P_LAST) begin
                        st_d  = S_IDLE;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so the registered word lines up with state.
    logic              sfp_wb, sfp_acc, sfp_div, ofifo_rd;
    logic              execute, load, qmem_rd, qmem_wr;
    logic              kmem_rd, kmem_wr, pmem_rd, pmem_wr;
    logic [ADDR_W-1:0] qk_addr, p_addr;

    always_comb begin
        sfp_wb   = 1'b0;
        sfp_acc  = 1'b0;
        sfp_div  = 1'b0;
        ofifo_rd = 1'b0;
        execute  = 1'b0;
        load     = 1'b0;
        qmem_rd  = 1'b0;
        qmem_wr  = 1'b0;
        kmem_rd  = 1'b0;
        kmem_wr  = 1'b0;
        pmem_rd  = 1'b0;
        pmem_wr  = 1'b0;
        qk_addr  = '0;
        p_addr   = '0;
        opv_d    = 1'b0;
        unique case (st_d)
            S_Q_WR: begin
                qmem_wr = 1'b1;
                qk_addr = cnt_d[ADDR_W-1:0];
            end
            S_K_WR: begin
                kmem_wr = 1'b1;
                qk_addr = cnt_d[ADDR_W-1:0];
            end
            S_K_LD: begin
                load    = 1'b1;
                kmem_rd = (cnt_d < K_END);
                qk_addr = cnt_d[ADDR_W-1:0];
            end
            S_EXEC: begin
                execute = 1'b1;
                qmem_rd = 1'b1;
                qk_addr = cnt_d[ADDR_W-1:0];
            end
            S_P_WR: begin
                ofifo_rd = 1'b1;
                pmem_wr  = 1'b1;
                p_addr   = cnt_d[ADDR_W-1:0];
            end
`ifdef ATTN_SEQ_SFP_EN
            S_SFP: begin
                p_addr = cnt_d[ADDR_W-1:0];
                case (beat_d)
                    '0:     pmem_rd = 1'b1;
                    B_ACC:  sfp_acc = 1'b1;
                    B_DIV:  sfp_div = 1'b1;
                    B_WB: begin
                        sfp_wb  = 1'b1;
                        pmem_wr = 1'b1;
                    end
                    B_LAST: pmem_wr = 1'b1;
                    default: ;
                endcase
            end
`endif
            S_GEN_OUT: begin
                pmem_rd = 1'b1;
                p_addr  = cnt_d[ADDR_W-1:0];
                opv_d   = 1'b1;
            end
            default: ;
        endcase
        inst_d = {sfp_wb, sfp_acc, sfp_div, ofifo_rd, qk_addr, p_addr,
                  execute, load, qmem_rd, qmem_wr,
                  kmem_rd, kmem_wr, pmem_rd, pmem_wr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= S_IDLE;
            cnt_q    <= '0;
            inst     <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            inst     <= inst_d;
            op_valid <= opv_d;
            busy     <= (st_d != S_IDLE);
            done     <= (st_d == S_IDLE);
        end
    end

`ifdef ATTN_SEQ_SFP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

    assign state = st_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: scoreboard bench for attn_seq_ctrl with default parameters.
// Stimulus pushes a hand-written per-cycle trace; a monitor pops it while busy.
module tb_attn_seq_ctrl;

    localparam int IW = 20;

    logic          clk = 1'b0;
    logic          reset, start, abort, ld_done, exec_done, out_wr;
    logic [IW-1:0] inst;
    logic          done, op_valid, busy;
    logic [3:0]    state;

    always #5 clk = ~clk;

    attn_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .ld_done   (ld_done),
        .exec_done (exec_done),
        .out_wr    (out_wr),
        .inst      (inst),
        .done      (done),
        .op_valid  (op_valid),
        .busy      (busy),
        .state     (state)
    );

    localparam logic [IW-1:0] WB   = 20'h80000;
    localparam logic [IW-1:0] ACC  = 20'h40000;
    localparam logic [IW-1:0] DIV  = 20'h20000;
    localparam logic [IW-1:0] OFRD = 20'h10000;
    localparam logic [IW-1:0] EX   = 20'h00080;
    localparam logic [IW-1:0] LD   = 20'h00040;
    localparam logic [IW-1:0] QRD  = 20'h00020;
    localparam logic [IW-1:0] QWR  = 20'h00010;
    localparam logic [IW-1:0] KRD  = 20'h00008;
    localparam logic [IW-1:0] KWR  = 20'h00004;
    localparam logic [IW-1:0] PRD  = 20'h00002;
    localparam logic [IW-1:0] PWR  = 20'h00001;
    localparam logic [IW-1:0] ALL  = 20'hFFFFF;
    localparam logic [IW-1:0] QKM  = 20'h0F000;

    typedef struct {
        logic [3:0]    st;
        logic [IW-1:0] inst;
        logic [IW-1:0] mask;
        logic          opv;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_pop  = 0;
    bit   mon_en = 1'b0;
    bit   prev_busy = 1'b0;

    function automatic logic [IW-1:0] qk(input int a);
        return IW'((a % 16) << 12);
    endfunction

    function automatic logic [IW-1:0] pa(input int a);
        return IW'((a % 16) << 8);
    endfunction

    task automatic push(input logic [3:0] s, input logic [IW-1:0] i,
                        input logic [IW-1:0] m, input logic o);
        exp_t e;
        e.st = s; e.inst = i; e.mask = m; e.opv = o;
        q.push_back(e);
    endtask

    // Expected per-cycle trace of one pass, from Q_WR through the first IDLE cycle.
    task automatic push_pass(input int kld_n, input int exec_n,
                             input int of_n, input int abort_at);
        for (int i = 0; i < 16; i++) push(4'd1, QWR | qk(i), ALL, 1'b0);
        for (int i = 0; i < 8; i++)  push(4'd2, KWR | qk(i), ALL, 1'b0);
        for (int i = 0; i < kld_n; i++) begin
            if (i < 8) push(4'd3, LD | KRD | qk(i), ALL, 1'b0);
            else       push(4'd3, LD, ALL & ~QKM, 1'b0);
        end
        for (int i = 0; i < 4; i++) push(4'd4, '0, ALL, 1'b0);
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) push(4'd5, EX | QRD | qk(i), ALL, 1'b0);
            push(4'd0, '0, ALL, 1'b0);
            return;
        end
        for (int i = 0; i < exec_n; i++) push(4'd5, EX | QRD | qk(i), ALL, 1'b0);
        for (int i = 0; i < of_n; i++)   push(4'd6, '0, ALL, 1'b0);
        for (int i = 0; i < 8; i++)      push(4'd7, OFRD | PWR | pa(i), ALL, 1'b0);
`ifdef ATTN_SEQ_SFP_EN
        for (int r = 0; r < 8; r++) begin
            push(4'd8, PRD | pa(r), ALL, 1'b0);
            push(4'd8, ACC | pa(r), ALL, 1'b0);
            push(4'd8, pa(r), ALL, 1'b0);
            push(4'd8, pa(r), ALL, 1'b0);
            push(4'd8, DIV | pa(r), ALL, 1'b0);
            push(4'd8, WB | PWR | pa(r), ALL, 1'b0);
            push(4'd8, PWR | pa(r), ALL, 1'b0);
        end
`endif
        for (int i = 0; i < 8; i++) push(4'd9, PRD | pa(i), ALL, 1'b1);
        push(4'd0, '0, ALL, 1'b0);
    endtask

    // Monitor: the DUT presents a beat while busy and on the cycle it returns to IDLE.
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && (busy || prev_busy)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: state=%0d inst=%05h with no expected entry",
                             state, inst);
                end else begin
                    e = q.pop_front();
                    ok = (state === e.st) &&
                         ((inst & e.mask) === (e.inst & e.mask)) &&
                         (op_valid === e.opv) &&
                         (done === (e.st == 4'd0)) &&
                         (busy === (e.st != 4'd0));
                    if (!ok) begin
                        errors++;
                        $display("FAIL trace[%0d]: got state=%0d inst=%05h op_valid=%0b done=%0b busy=%0b, required state=%0d inst=%05h mask=%05h op_valid=%0b",
                                 n_pop, state, inst, op_valid, done, busy,
                                 e.st, e.inst, e.mask, e.opv);
                    end
                    n_pop++;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_state(input logic [3:0] s);
        int t;
        t = 0;
        @(negedge clk);
        while (state !== s && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (state !== s) begin
            errors++;
            checks++;
            $display("FAIL wait_state: state=%0d, required %0d within 400 cycles", state, s);
        end
    endtask

    task automatic set_in(input int which, input logic v);
        case (which)
            0:       ld_done   = v;
            1:       exec_done = v;
            2:       out_wr    = v;
            default: abort     = v;
        endcase
    endtask

    // Called on the first cycle of a state; the input is sampled at the end of cycle n.
    task automatic pulse(input int which, input int n);
        if (n > 1) begin
            repeat (n-1) @(posedge clk);
            #1;
        end
        set_in(which, 1'b1);
        @(posedge clk);
        #1;
        set_in(which, 1'b0);
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_pass(input int kld_n, input int exec_n,
                              input int of_n, input int abort_at);
        // A start while already busy must be ignored.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_state(4'd3);
        pulse(0, kld_n);
        wait_state(4'd5);
        if (abort_at > 0) begin
            pulse(3, abort_at);
        end else begin
            pulse(1, exec_n);
            wait_state(4'd6);
            pulse(2, of_n);
        end
    endtask

    task automatic run_pass(input int kld_n, input int exec_n,
                            input int of_n, input int abort_at);
        push_pass(kld_n, exec_n, of_n, abort_at);
        kick();
        drive_pass(kld_n, exec_n, of_n, abort_at);
    endtask

    task automatic finish_pass(input string name);
        wait_state(4'd0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected beats left, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_rst(input string name);
        checks++;
        if (!(state === 4'd0 && inst === '0 && op_valid === 1'b0 &&
              busy === 1'b0 && done === 1'b1)) begin
            errors++;
            $display("FAIL %s: got state=%0d inst=%05h op_valid=%0b busy=%0b done=%0b, required 0 00000 0 0 1",
                     name, state, inst, op_valid, busy, done);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        ld_done   = 1'b0;
        exec_done = 1'b0;
        out_wr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_rst("por_reset");
        mon_en = 1'b1;

        // Start accepted on the very first edge after reset release.
        push_pass(10, 18, 3, 0);
        reset = 1'b0;
        kick();
        drive_pass(10, 18, 3, 0);
        finish_pass("pass_a");

        // Abort on the third EXEC cycle, then a clean restart.
        run_pass(8, 0, 0, 3);
        finish_pass("abort");
        run_pass(1, 1, 1, 0);
        finish_pass("pass_c");

        // Abort wins over start while idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_beats_start: state=%0d done=%0b, required 0 1", state, done);
        end

        // Asynchronous reset in the middle of a pass.
        run_pass(8, 5, 2, 0);
`ifdef ATTN_SEQ_SFP_EN
        wait_state(4'd8);
        repeat (23) @(negedge clk);
`else
        wait_state(4'd9);
        repeat (3) @(negedge clk);
`endif
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check_rst("reset_mid_pass");
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_rst("reset_hold");

        mon_en = 1'b1;
        push_pass(3, 20, 1, 0);
        reset = 1'b0;
        kick();
        drive_pass(3, 20, 1, 0);
        finish_pass("pass_e");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
